noc_input_port: RTL and testbench
=================================

Name: noc_input_port

Overview:
- Router input port that sits on the requesting side of the per-output two-way and round-robin arbiters.
- Buffers incoming single-flit packets in a FIFO and computes an XY route for the head flit.
- Raises a one-hot request to the selected output arbiter, holds it until granted, then forwards the flit with valid/ready.
- One instance per router input (Local, N, S, E, W).

Parameters:
- FLIT_W, 64, flit width in bits.
- COORD_W, 4, width of each destination coordinate field.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- LOCAL_X, 0, this router's X coordinate.
- LOCAL_Y, 0, this router's Y coordinate.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream flit valid.
- in_flit  in  FLIT_W  upstream flit; dest_x = [FLIT_W-1 -: COORD_W], dest_y = the next COORD_W bits below it.
- in_ready  out  1  FIFO can accept a flit.
- req_o  out  5  one-hot request to output arbiters; bit 0 Local, 1 North, 2 South, 3 East, 4 West.
- gnt_i  in  5  grant per output arbiter back to this port.
- out_valid  out  1  head flit presented to the granted output.
- out_flit  out  FLIT_W  head flit data.
- out_port  out  3  index of the granted output (0–4).
- out_ready  in  1  granted output accepts the flit.

Behaviour:
- Reset (synchronous, highest priority):
  - FIFO emptied, state IDLE.
  - req_o=0, out_valid=0, out_port=0, out_flit=0, in_ready=1.
  - In-flight flits are dropped; a request is withdrawn on the next edge.
- FIFO:
  - Push when in_valid & in_ready. in_ready = !full, registered-count based, no combinational path from out_ready.
  - Pop only in SEND when out_ready=1.
  - Push and pop on the same edge: count unchanged, pointers wrap modulo DEPTH.
  - When full, in_ready=0 even if a pop occurs that cycle.
- XY routing of head flit, evaluated in IDLE:
  - dest_x > LOCAL_X → East(3); dest_x < LOCAL_X → West(4).
  - Else dest_y > LOCAL_Y → North(1); dest_y < LOCAL_Y → South(2).
  - Else Local(0).
  - Comparisons are unsigned.
- State machine (req_o and out_valid are registered outputs of the state):
  - IDLE: if FIFO non-empty, latch port := route(head) and go to REQ. Otherwise stay.
  - REQ: req_o = 1<<port. If gnt_i[port]=1, go to SEND; other gnt_i bits are ignored.
  - SEND: req_o stays asserted (locks the arbiter); out_valid=1, out_flit=head, out_port=port. If out_ready, pop and go to IDLE. gnt_i is ignored in SEND, so grant withdrawal does not abort.
- Latency: a flit pushed at edge T gives req_o high after T+1. A grant in that cycle gives out_valid after T+2. A minimum transfer pops at T+3.
- Back-to-back flits: IDLE is revisited between packets, giving one bubble cycle with req_o=0. This lets the arbiter's round-robin rotate.
- out_flit is stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: NOC_INPUT_PORT_STATS_EN.
- Defined: adds outputs stat_fwd[15:0] and stat_wait[15:0], both reset to 0 and saturating at 16'hFFFF.
  - stat_fwd increments on each pop.
  - stat_wait increments each cycle in REQ with gnt_i[port]=0.
- Undefined: these ports and counters do not exist; functional behaviour is identical.

Decomposition:
- Shared package noc_pkg holds:
  - Port index constants PORT_LOCAL/NORTH/SOUTH/EAST/WEST.
  - NUM_PORTS=5.
  - Flit field position helpers for dest_x/dest_y.
  - FSM state encoding.
- Sub-module noc_sync_fifo (params WIDTH, DEPTH; push/pop/full/empty/head) holds the storage. The route function lives in noc_pkg.

Test Plan:
- LOCAL=(1,1), flit dest (3,1) pushed at T → req_o=5'b01000 after T+1; gnt_i=5'b01000 → out_valid=1, out_port=3 after T+2; out_ready=1 → pop, in_ready=1.
- Dests (0,1), (1,3), (1,0), (1,1) → req_o=5'b10000, 5'b00010, 5'b00100, 5'b00001 respectively.
- Hold gnt_i=0 for 10 cycles in REQ, with gnt_i=5'b00001 on a wrong port → req_o stays 5'b01000, out_valid=0; stat_wait=10 with macro.
- Push 5 flits with DEPTH=4 and out_ready=0 → in_ready=0 after 4 pushes, the 5th is not accepted; drain → flits emerge in order, one IDLE bubble between each.
- In SEND, drop gnt_i and hold out_ready=0 for 3 cycles → out_valid and out_flit stay stable, req_o stays asserted; then out_ready=1 → single pop.
- Assert reset during SEND with 3 flits buffered → after the edge req_o=0, out_valid=0, FIFO empty, in_ready=1, stats=0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: output port indices, input-port FSM encoding,
// flit destination field helpers and the XY route function.
package noc_pkg;

    localparam int unsigned NUM_PORTS = 5;

    localparam logic [2:0] PORT_LOCAL = 3'd0;
    localparam logic [2:0] PORT_NORTH = 3'd1;
    localparam logic [2:0] PORT_SOUTH = 3'd2;
    localparam logic [2:0] PORT_EAST  = 3'd3;
    localparam logic [2:0] PORT_WEST  = 3'd4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    // Coordinates are zero-extended to this width before comparison.
    localparam int unsigned ROUTE_COORD_W = 16;

    function automatic int unsigned dest_x_msb(input int unsigned flit_w);
        return flit_w - 1;
    endfunction

    function automatic int unsigned dest_y_msb(input int unsigned flit_w,
                                               input int unsigned coord_w);
        return flit_w - coord_w - 1;
    endfunction

    // X is resolved first, then Y; a match on both delivers locally.
    function automatic logic [2:0] xy_route(input logic [ROUTE_COORD_W-1:0] dest_x,
                                            input logic [ROUTE_COORD_W-1:0] dest_y,
                                            input logic [ROUTE_COORD_W-1:0] local_x,
                                            input logic [ROUTE_COORD_W-1:0] local_y);
        if (dest_x > local_x)      return PORT_EAST;
        else if (dest_x < local_x) return PORT_WEST;
        else if (dest_y > local_y) return PORT_NORTH;
        else if (dest_y < local_y) return PORT_SOUTH;
        else                       return PORT_LOCAL;
    endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous FIFO with registered occupancy count; DEPTH must be a power of two.
module noc_sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + (PTR_W+1)'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - (PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: rtl/noc_input_port.sv
// Router input port: buffers flits, XY-routes the head, requests and holds an output arbiter.
// Optional macro NOC_INPUT_PORT_STATS_EN adds stat_fwd/stat_wait saturating counters.
module noc_input_port
    import noc_pkg::*;
#(
    parameter int unsigned FLIT_W  = 64,
    parameter int unsigned COORD_W = 4,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LOCAL_X = 0,
    parameter int unsigned LOCAL_Y = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [FLIT_W-1:0]    in_flit,
    output logic                 in_ready,
    output logic [NUM_PORTS-1:0] req_o,
    input  logic [NUM_PORTS-1:0] gnt_i,
    output logic                 out_valid,
    output logic [FLIT_W-1:0]    out_flit,
    output logic [2:0]           out_port,
`ifdef NOC_INPUT_PORT_STATS_EN
    output logic [15:0]          stat_fwd,
    output logic [15:0]          stat_wait,
`endif
    input  logic                 out_ready
);

    localparam int unsigned DX_MSB = dest_x_msb(FLIT_W);
    localparam int unsigned DY_MSB = dest_y_msb(FLIT_W, COORD_W);

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [FLIT_W-1:0] w_head;
    logic [2:0]        w_route;
    logic [1:0]        r_state;
    logic [2:0]        r_port;

    assign w_push = in_valid && !w_full;
    assign w_pop  = (r_state == ST_SEND) && out_ready;

    noc_sync_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (in_flit),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    assign w_route = xy_route(ROUTE_COORD_W'(w_head[DX_MSB -: COORD_W]),
                              ROUTE_COORD_W'(w_head[DY_MSB -: COORD_W]),
                              ROUTE_COORD_W'(LOCAL_X),
                              ROUTE_COORD_W'(LOCAL_Y));

    // The request stays up through SEND so the arbiter cannot re-grant mid-transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_port  <= PORT_LOCAL;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_port  <= w_route;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (gnt_i[r_port]) begin
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = !w_full;
    assign req_o     = (r_state != ST_IDLE) ? (NUM_PORTS'(1) << r_port) : '0;
    assign out_valid = (r_state == ST_SEND);
    assign out_flit  = out_valid ? w_head : '0;
    assign out_port  = out_valid ? r_port : 3'd0;

`ifdef NOC_INPUT_PORT_STATS_EN
    logic [15:0] r_stat_fwd;
    logic [15:0] r_stat_wait;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_fwd  <= '0;
            r_stat_wait <= '0;
        end else begin
            if (w_pop && (r_stat_fwd != 16'hFFFF)) begin
                r_stat_fwd <= r_stat_fwd + 16'd1;
            end
            if ((r_state == ST_REQ) && !gnt_i[r_port] && (r_stat_wait != 16'hFFFF)) begin
                r_stat_wait <= r_stat_wait + 16'd1;
            end
        end
    end

    assign stat_fwd  = r_stat_fwd;
    assign stat_wait = r_stat_wait;
`endif

endmodule

// File: tb/tb_noc_input_port.sv
// Scoreboard bench for noc_input_port at LOCAL=(1,1): directed latency/routing/full/hold/reset
// scenarios followed by randomized traffic, all checked by a negedge monitor.
module tb_noc_input_port;

    localparam int unsigned FW  = 64;
    localparam int unsigned CW  = 4;
    localparam int unsigned DEP = 4;
    localparam int          LX  = 1;
    localparam int          LY  = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [63:0] in_flit = '0;
    logic        in_ready;
    logic [4:0]  req_o;
    logic [4:0]  gnt_i = '0;
    logic        out_valid;
    logic [63:0] out_flit;
    logic [2:0]  out_port;
    logic        out_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    noc_input_port #(
        .FLIT_W  (FW),
        .COORD_W (CW),
        .DEPTH   (DEP),
        .LOCAL_X (LX),
        .LOCAL_Y (LY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_flit   (in_flit),
        .in_ready  (in_ready),
        .req_o     (req_o),
        .gnt_i     (gnt_i),
        .out_valid (out_valid),
        .out_flit  (out_flit),
        .out_port  (out_port),
        .out_ready (out_ready)
    );

    // Reference XY rule on plain integers.
    function automatic int route_model(input logic [63:0] f);
        int dx;
        int dy;
        dx = int'(f[63:60]);
        dy = int'(f[59:56]);
        if (dx > LX) return 3;
        if (dx < LX) return 4;
        if (dy > LY) return 1;
        if (dy < LY) return 2;
        return 0;
    endfunction

    function automatic logic [4:0] onehot(input int p);
        logic [4:0] v;
        v = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    function automatic logic [63:0] mkflit(input int x, input int y);
        logic [63:0] f;
        f = {$urandom(), $urandom()};
        f[63:60] = 4'(x);
        f[59:56] = 4'(y);
        return f;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: tracks expected FIFO contents and checks every visible output.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else begin
            check("in_ready", in_ready, 64'(sb.size() < DEP));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("out_valid_when_empty", out_valid, 0);
                end else begin
                    check("out_flit", out_flit, sb[0]);
                    check("out_port", out_port, route_model(sb[0]));
                    check("send_req", req_o, onehot(route_model(sb[0])));
                    if (out_ready) void'(sb.pop_front());
                end
            end else if (sb.size() == 0) begin
                check("req_idle", req_o, 0);
            end else if (req_o != 0) begin
                check("req_route", req_o, onehot(route_model(sb[0])));
            end
            if (in_valid && in_ready) sb.push_back(in_flit);
        end
    end

    task automatic push_flit(input logic [63:0] f);
        int n;
        step();
        in_valid = 1'b1;
        in_flit  = f;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("push_timeout", in_ready, 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        @(negedge clk);
        while (req_o == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("req_timeout", 64'(req_o != 0), 1);
    endtask

    // Grant after `delay` REQ cycles (driving idle_gnt meanwhile), stall `stall` SEND cycles.
    task automatic serve(input int delay, input int stall, input logic [4:0] idle_gnt);
        logic [4:0] r;
        wait_req();
        r = req_o;
        for (int i = 0; i < delay; i++) begin
            step();
            gnt_i = idle_gnt;
            @(negedge clk);
            check("wait_req_hold", req_o, r);
            check("wait_no_valid", out_valid, 0);
        end
        step();
        gnt_i = r;
        step();
        gnt_i = '0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_req", req_o, r);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        @(negedge clk);
        check("bubble_req", req_o, 0);
        check("bubble_valid", out_valid, 0);
    endtask

    initial begin
        logic [63:0] f;
        int n;

        repeat (3) step();
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_req", req_o, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_port", out_port, 0);
        check("rst_out_flit", out_flit, 0);

        // Minimum-latency transfer to East.
        f = mkflit(3, 1);
        step();
        in_valid = 1'b1;
        in_flit  = f;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_idle_req", req_o, 0);
        step();
        gnt_i = 5'b01000;
        @(negedge clk);
        check("lat_req", req_o, 5'b01000);
        check("lat_req_no_valid", out_valid, 0);
        step();
        gnt_i = '0;
        out_ready = 1'b1;
        @(negedge clk);
        check("lat_valid", out_valid, 1);
        check("lat_port", out_port, 3);
        check("lat_flit", out_flit, f);
        step();
        out_ready = 1'b0;
        @(negedge clk);
        check("lat_done_valid", out_valid, 0);
        check("lat_done_req", req_o, 0);
        check("lat_done_ready", in_ready, 1);

        // Remaining routing directions.
        push_flit(mkflit(0, 1));
        serve(0, 0, '0);
        push_flit(mkflit(1, 3));
        serve(1, 0, '0);
        push_flit(mkflit(1, 0));
        serve(0, 1, '0);
        push_flit(mkflit(1, 1));
        serve(2, 0, '0);

        // Long wait with a grant on a wrong port.
        push_flit(mkflit(3, 1));
        serve(10, 0, 5'b00001);

        // Fill past capacity with no grant and no out_ready.
        step();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_flit  = mkflit(i % 4, (i + 1) % 4);
            @(negedge clk);
            check("fill_in_ready", in_ready, 64'(i < 4));
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) serve(0, 0, '0);

        // Stall in SEND with grant withdrawn.
        push_flit(mkflit(2, 2));
        serve(0, 3, '0);

        // Reset in SEND with three flits buffered.
        push_flit(mkflit(3, 0));
        push_flit(mkflit(0, 0));
        push_flit(mkflit(1, 2));
        wait_req();
        step();
        gnt_i = req_o;
        step();
        gnt_i = '0;
        @(negedge clk);
        check("pre_rst_valid", out_valid, 1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_req", req_o, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_flit", out_flit, 0);
        repeat (3) step();
        @(negedge clk);
        check("mid_rst_stays_idle", req_o, 0);

        // Randomized traffic with random grants (possibly on other ports) and stalls.
        for (int c = 0; c < 600; c++) begin
            logic [4:0] g;
            step();
            in_valid  = ($urandom_range(0, 2) != 0);
            in_flit   = mkflit(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            g         = 5'($urandom());
            gnt_i     = ($urandom_range(0, 2) != 0) ? (g | req_o) : (g & ~req_o);
            out_ready = ($urandom_range(0, 1) != 0);
        end
        step();
        in_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            gnt_i     = req_o;
            out_ready = 1'b1;
            step();
            n++;
        end
        gnt_i     = '0;
        out_ready = 1'b0;
        check("drain_remaining", sb.size(), 0);
        @(negedge clk);
        check("drain_idle_req", req_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
